// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared defaults and types for the register-based synchronous FIFO.
//   FIFO_DATA_W : default word width in bits
//   FIFO_DEPTH  : default number of storage entries (power of two, >= 2)
//   word_t      : one FIFO word at the default width
//   FIFO_PTR_W  : pointer width, indexes 0..DEPTH-1
//   FIFO_CNT_W  : occupancy counter width, holds 0..DEPTH
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DATA_W = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam int FIFO_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W  = FIFO_PTR_W + 1;

    typedef logic [FIFO_DATA_W-1:0] word_t;

endpackage : fifo_pkg

// File: rtl/fifo_regfile.sv
// -----------------------------------------------------------------------------
// fifo_regfile
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port. Contents are not reset.
//   clk_i   : clock, write on rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : combinational read data at raddr_i
// -----------------------------------------------------------------------------
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_regfile

// File: rtl/fifo_top.sv
// -----------------------------------------------------------------------------
// fifo_top
// Single-clock FIFO with registered output word and registered flags.
//   clk_i    : system clock, rising edge
//   rst_i    : synchronous active-low reset
//   push_i   : write request (level, one write per cycle)
//   data_i   : write data
//   pop_i    : read request (level, one read per cycle)
//   data_o   : last popped word, held between pops
//   full_o   : DEPTH words stored
//   pnding_o : at least one word stored
// -----------------------------------------------------------------------------
module fifo_top
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              pnding_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              full_q,   full_d;
    logic              pnding_q, pnding_d;
    logic [DATA_W-1:0] dout_q,   dout_d;
    logic [DATA_W-1:0] rdata;
    logic              pop_ok;
    logic              push_ok;

    // A pop is only taken when data is pending, so a push into an empty
    // FIFO never bypasses to data_o. When full, a same-cycle pop frees
    // the slot the push lands in.
    assign pop_ok  = pop_i & pnding_q;
    assign push_ok = push_i & (~full_q | pop_ok);

    fifo_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_regfile (
        .clk_i   (clk_i),
        .we_i    (push_ok & rst_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        // Pointers wrap naturally since DEPTH is a power of two.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            dout_d   = rdata;
        end

        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        full_d   = (count_d == CNT_W'(DEPTH));
        pnding_d = (count_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            pnding_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            pnding_q <= pnding_d;
            dout_q   <= dout_d;
        end
    end

    assign data_o   = dout_q;
    assign full_o   = full_q;
    assign pnding_o = pnding_q;

endmodule : fifo_top

// File: tb/tb_fifo_top.sv
// -----------------------------------------------------------------------------
// tb_fifo_top
// Directed and random stimulus for fifo_top, checked against a queue-based
// reference model of FIFO behaviour.
// -----------------------------------------------------------------------------
module tb_fifo_top;
    import fifo_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        push_i;
    logic        pop_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        full_o;
    logic        pnding_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    word_t mq[$];
    word_t mdout;

    always #5 clk_i = ~clk_i;

    fifo_top dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (push_i),
        .data_i   (data_i),
        .pop_i    (pop_i),
        .data_o   (data_o),
        .full_o   (full_o),
        .pnding_o (pnding_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic cyc(input logic rst_n, input logic psh, input logic pp, input logic [31:0] d);
        bit pop_ok, push_ok;
        rst_i  = rst_n;
        push_i = psh;
        pop_i  = pp;
        data_i = d;
        @(posedge clk_i);
        if (!rst_n) begin
            mq.delete();
            mdout = '0;
        end else begin
            pop_ok  = pp && (mq.size() > 0);
            push_ok = psh && ((mq.size() < DEPTH) || pop_ok);
            if (pop_ok)  mdout = mq.pop_front();
            if (push_ok) mq.push_back(d);
        end
        #1;
        chk("data_o",   data_o,             mdout);
        chk("full_o",   {31'b0, full_o},    {31'b0, mq.size() == DEPTH});
        chk("pnding_o", {31'b0, pnding_o},  {31'b0, mq.size() != 0});
    endtask

    logic [31:0] fill_v [4];
    logic [31:0] wrap_v [4];

    initial begin
        fill_v = '{32'h00F2F277, 32'h0000A1A1, 32'h0000FFFF, 32'h00002222};
        wrap_v = '{32'h0000A1A1, 32'h0000FFFF, 32'h00002222, 32'h00003333};
        mdout  = '0;

        // Reset held, then released; pop on empty leaves data_o at zero.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_data", data_o, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0);
        chk("empty_pop_data", data_o, 32'h0);

        // Fill with pulses, then a dropped fifth push.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, fill_v[i]);
            if (i == 0) chk("pnding_after_first", {31'b0, pnding_o}, 32'h1);
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
        end
        chk("full_after_fourth", {31'b0, full_o}, 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 32'h00002222);
        chk("full_after_drop", {31'b0, full_o}, 32'h1);

        // Drain with five pop pulses.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 32'h0);
            chk("drain_data", data_o, fill_v[(i < 4) ? i : 3]);
            if (i == 0) chk("full_after_pop", {31'b0, full_o}, 32'h0);
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
        end
        chk("pnding_after_drain", {31'b0, pnding_o}, 32'h0);

        // Wrap-around: pointers cross the end of the array.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, wrap_v[i]);
        chk("wrap_full", {31'b0, full_o}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 32'h0);
            chk("wrap_data", data_o, wrap_v[i]);
        end

        // Simultaneous push/pop while full.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, fill_v[i]);
        cyc(1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
        chk("simul_full_data", data_o, fill_v[0]);
        chk("simul_full_flag", {31'b0, full_o}, 32'h1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 32'h0);
        chk("simul_newest_last", data_o, 32'hDEADBEEF);

        // Simultaneous push/pop while empty: push only, no bypass.
        cyc(1'b1, 1'b1, 1'b1, 32'h12345678);
        chk("simul_empty_data", data_o, 32'hDEADBEEF);
        chk("simul_empty_pnding", {31'b0, pnding_o}, 32'h1);
        cyc(1'b1, 1'b0, 1'b1, 32'h0);
        chk("simul_empty_pop", data_o, 32'h12345678);

        // Reset mid-operation with a push in the same cycle.
        cyc(1'b1, 1'b1, 1'b0, 32'h0000AAAA);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000BBBB);
        cyc(1'b0, 1'b1, 1'b0, 32'h0000CCCC);
        chk("midrst_data", data_o, 32'h0);
        chk("midrst_pnding", {31'b0, pnding_o}, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0);
        chk("midrst_pop_empty", data_o, 32'h0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_top

// File: doc/fifo_top.md
Name: fifo_top

Overview:
- Synchronous single-clock FIFO, 32-bit words, register-based storage.
- Sits between a word producer (push side) and a consumer (pop side).
- Flags `full_o` (no room) and `pnding_o` (data pending, i.e. not empty).
- `data_o` is a registered output loaded on each accepted pop.

Parameters:
- DATA_W, 32, word width in bits.
- DEPTH, 4, number of storage entries; power of two, at least 2.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- push_i  in  1  write request; one write per cycle sampled high.
- data_i  in  DATA_W  write data, captured with an accepted push.
- pop_i  in  1  read request; one read per cycle sampled high.
- data_o  out  DATA_W  last popped word (registered).
- full_o  out  1  high when DEPTH words are stored.
- pnding_o  out  1  high when at least one word is stored.

Behaviour:
- Reset:
  - Sampled at a rising edge with rst_i=0.
  - Clears write pointer, read pointer and count; data_o=0.
  - Resulting flags: full_o=0, pnding_o=0.
  - Storage contents need not be cleared.
  - Reset overrides push/pop in the same cycle.
  - A mid-operation reset discards all stored data.
- Push:
  - Accepted when push_i=1 and (not full, or pop accepted in the same cycle).
  - Writes data_i to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
  - Push while full without a pop: silently dropped, no state change.
- Pop:
  - Accepted when pop_i=1 and pnding_o=1.
  - data_o <= mem[rd_ptr] at that edge; rd_ptr increments modulo DEPTH.
  - Pop while empty: ignored; data_o holds its previous value.
- data_o holds its value between accepted pops.
- Level semantics: a request held high for N cycles performs up to N operations. No edge detection.
- Simultaneous push and pop:
  - When not empty: both happen and count is unchanged.
  - When full: both happen; the pop frees the slot the push uses.
  - When empty: only the push happens. The pop is ignored, and data_o does not bypass data_i.
- Counter: count width clog2(DEPTH)+1, range 0..DEPTH.
- Flags are registered state derived from count, valid the cycle after the causing edge:
  - full_o = (count == DEPTH).
  - pnding_o = (count != 0).
- Pointers wrap with no special handling; ordering is strictly first-in, first-out across the wrap.
- Latency: a word pushed at edge k can be popped at edge k+1 and appears on data_o after that edge.

Decomposition:
- Package `fifo_pkg`:
  - DATA_W and DEPTH defaults.
  - Typedef `word_t` (logic [DATA_W-1:0]).
  - Pointer and count widths via $clog2.
- Sub-module `fifo_regfile`: DEPTH x DATA_W register array with one synchronous write port and an asynchronous read at rd_ptr.
- fifo_top holds pointers, count, flags, accept logic and the data_o register.

Test Plan:
- Reset: hold rst_i=0 for several cycles, then release -> data_o=0, full_o=0, pnding_o=0; a pop in this state leaves data_o=0.
- Fill: push 0x00F2F277, 0x0000A1A1, 0x0000FFFF, 0x00002222 as 1-cycle pulses:
  - pnding_o=1 after the first push.
  - full_o=1 after the fourth.
  - A fifth push of 0x00002222 is dropped; count stays 4.
- Drain: five 1-cycle pop pulses:
  - data_o sequence 0x00F2F277, 0x0000A1A1, 0x0000FFFF, 0x00002222.
  - full_o=0 after the first pop; pnding_o=0 after the fourth.
  - The fifth pop is ignored; data_o stays 0x00002222.
- Wrap-around: after the drain, push 0xA1A1, 0xFFFF, 0x2222, 0x3333 -> full_o=1; popping all four returns them in order.
- Simultaneous:
  - push_i=pop_i=1 for one cycle when full -> data_o = oldest word, newest word stored, full_o stays 1.
  - Same when empty -> only the push is taken; pnding_o=1, data_o unchanged.
- Reset mid-operation: with 2 words stored, assert rst_i=0 for one cycle with push_i=1 -> count 0, flags 0, data_o=0, push discarded.
